// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter types: frame state encoding and serial line levels.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
// Latency: bit_done is asserted CLKS_PER_BIT-1 cycles after clear drops. No backpressure.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = (cnt == LAST) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter (start, BITS_N data LSB first, optional even parity under UART_TX_PARITY_EN, stop).
// Latency: line drops on the accepting edge. Backpressure: ready low for the whole frame.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int BITS_N       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_N-1:0] data_tx,
    input  logic              valid,
    output logic              ready,
    output logic              uart_out
);

    import uart_tx_pkg::*;

    localparam int IW = $clog2(BITS_N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BITS_N - 1);

    state_t            state;
    logic [BITS_N-1:0] shift;
    logic [IW-1:0]     idx;
    logic              bit_done;
`ifdef UART_TX_PARITY_EN
    logic              parity;
`endif

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .bit_done(bit_done)
    );

    // The shift register moves right as each bit goes out, so bit 0 is always the next data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            uart_out <= LINE_IDLE;
            ready    <= 1'b1;
            shift    <= '0;
            idx      <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        shift    <= data_tx;
`ifdef UART_TX_PARITY_EN
                        parity   <= ^data_tx;
`endif
                        state    <= START;
                        uart_out <= START_BIT;
                        ready    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state    <= DATA;
                        idx      <= '0;
                        uart_out <= shift[0];
                        shift    <= shift >> 1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_out <= parity;
`else
                            state    <= STOP;
                            uart_out <= STOP_BIT;
`endif
                        end else begin
                            idx      <= idx + 1'b1;
                            uart_out <= shift[0];
                            shift    <= shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state    <= STOP;
                        uart_out <= STOP_BIT;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state    <= IDLE;
                        uart_out <= LINE_IDLE;
                        ready    <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_out <= LINE_IDLE;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at CLKS_PER_BIT=4, BITS_N=8; honours UART_TX_PARITY_EN.
module tb_uart_tx_core;

    localparam int CPB = 4;
    localparam int BN  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = BN + 3;
`else
    localparam int SLOTS = BN + 2;
`endif
    localparam int FL = SLOTS * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic [BN-1:0] data_tx;
    logic          valid;
    logic          ready;
    logic          uart_out;

    int tests = 0;
    int fails = 0;

    uart_tx_core #(
        .CLKS_PER_BIT(CPB),
        .BITS_N      (BN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_tx (data_tx),
        .valid   (valid),
        .ready   (ready),
        .uart_out(uart_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected line level for frame slot k (0 = start bit).
    function automatic logic exp_bit(input logic [BN-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= BN) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == BN + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Checks frame cycles from..FL-1; data_tx is overwritten with 'later' in cycle 1.
    task automatic frame_body(input string name, input logic [BN-1:0] d, input int from,
                              input logic [BN-1:0] later);
        for (int c = from; c < FL; c++) begin
            @(negedge clk);
            if (c == 1) data_tx = later;
            check($sformatf("%s c%0d line", name, c), uart_out, exp_bit(d, c / CPB));
            check($sformatf("%s c%0d ready", name, c), ready, 1'b0);
        end
    endtask

    task automatic send(input string name, input logic [BN-1:0] d, input logic [BN-1:0] later);
        data_tx = d;
        valid   = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        frame_body(name, d, 0, later);
        @(negedge clk);
        check({name, " end ready"}, ready, 1'b1);
        check({name, " end line"}, uart_out, 1'b1);
    endtask

    initial begin
        rst     = 1'b0;
        valid   = 1'b0;
        data_tx = '0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst async line", uart_out, 1'b1);
        check("rst async ready", ready, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check($sformatf("idle %0d line", i), uart_out, 1'b1);
            check($sformatf("idle %0d ready", i), ready, 1'b1);
        end

        send("b7B", 8'h7B, 8'h7B);
        send("b0A_stab", 8'h0A, 8'hFF);

        // Back-to-back with valid held high.
        data_tx = 8'h7D;
        valid   = 1'b1;
        @(posedge clk);
        #1 data_tx = 8'h0A;
        frame_body("b2b1", 8'h7D, 0, 8'h0A);
        @(negedge clk);
        check("b2b stop5 line", uart_out, 1'b1);
        check("b2b stop5 ready", ready, 1'b1);
        @(negedge clk);
        check("b2b start2 line", uart_out, 1'b0);
        check("b2b start2 ready", ready, 1'b0);
        valid = 1'b0;
        frame_body("b2b2", 8'h0A, 1, 8'h0A);
        @(negedge clk);
        check("b2b end ready", ready, 1'b1);
        check("b2b end line", uart_out, 1'b1);

        // Reset during data bit 3 of 0xF0 (line low there).
        data_tx = 8'hF0;
        valid   = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (17) @(negedge clk);
        check("midrst bit3 line", uart_out, 1'b0);
        check("midrst bit3 ready", ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst async line", uart_out, 1'b1);
        check("midrst async ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("postrst line", uart_out, 1'b1);
        check("postrst ready", ready, 1'b1);
        send("b55", 8'h55, 8'h55);

        send("b07", 8'h07, 8'h07);
`ifdef UART_TX_PARITY_EN
        check("parity fn 07", exp_bit(8'h07, BN + 1), 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
